// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DMA = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam int BURST_W = 4;

endpackage

// File: rtl/dmem_arb_sat_counter.sv
// Saturating up-counter with synchronous clear (highest priority) and load-to-one.
module dmem_arb_sat_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= WIDTH'(1);
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / DMA loader) arbiter for the single-port data RAM with burst-limited ownership.
// Optional ARB_STATS_EN adds saturating per-requester grant counters with a synchronous clear.
//
// state   | meaning
// IDLE    | no owner; round-robin against last_owner on a tie
// OWN_CPU | CPU granted last cycle; keeps the port until the burst limit if DMA waits
// OWN_DMA | DMA granted last cycle; keeps the port until the burst limit if CPU waits
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef ARB_STATS_EN
  input  logic                  stats_clr,
  output logic [15:0]           cpu_gnt_cnt,
  output logic [15:0]           dma_gnt_cnt,
`endif
  output logic [1:0]            owner
);

  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

  arb_state_e           state;
  logic                 last_owner;
  logic [BURST_W-1:0]   burst_cnt;
  logic                 burst_full;
  logic                 new_owner;
  logic                 any_gnt;
  logic                 burst_clr;
  logic                 burst_inc;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] dma_rdata_q;

  assign burst_full = (burst_cnt >= BURST_LIM);

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && dma_req) begin
          cpu_gnt = (last_owner == REQ_DMA);
          dma_gnt = (last_owner == REQ_CPU);
        end else begin
          cpu_gnt = cpu_req;
          dma_gnt = dma_req;
        end
      end
      OWN_CPU: begin
        if (cpu_req) begin
          dma_gnt = dma_req && burst_full;
          cpu_gnt = !(dma_req && burst_full);
        end else begin
          dma_gnt = dma_req;
        end
      end
      OWN_DMA: begin
        if (dma_req) begin
          cpu_gnt = cpu_req && burst_full;
          dma_gnt = !(cpu_req && burst_full);
        end else begin
          cpu_gnt = cpu_req;
        end
      end
      default: begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
      end
    endcase
  end

  // Command mux: everything reads as zero when nobody is granted.
  assign mem_en    = cpu_gnt | dma_gnt;
  assign mem_we    = cpu_gnt ? cpu_we    : (dma_gnt ? dma_we    : 1'b0);
  assign mem_addr  = cpu_gnt ? cpu_addr  : (dma_gnt ? dma_addr  : '0);
  assign mem_wdata = cpu_gnt ? cpu_wdata : (dma_gnt ? dma_wdata : '0);

  assign any_gnt   = cpu_gnt | dma_gnt;
  assign new_owner = (cpu_gnt && (state != OWN_CPU)) || (dma_gnt && (state != OWN_DMA));
  assign burst_inc = any_gnt && !new_owner;
  assign burst_clr = !any_gnt && (state != IDLE);

  dmem_arb_sat_counter #(
    .WIDTH (BURST_W),
    .MAX   (MAX_BURST)
  ) u_burst_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (burst_clr),
    .load1 (new_owner),
    .inc   (burst_inc),
    .cnt   (burst_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_owner  <= REQ_DMA;
      cpu_rvalid  <= 1'b0;
      dma_rvalid  <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      dma_rvalid <= dma_gnt & ~dma_we;
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (dma_rvalid) dma_rdata_q <= mem_rdata;
      if (cpu_gnt) begin
        state <= OWN_CPU;
      end else if (dma_gnt) begin
        state <= OWN_DMA;
      end else begin
        if (state == OWN_CPU) last_owner <= REQ_CPU;
        else if (state == OWN_DMA) last_owner <= REQ_DMA;
        state <= IDLE;
      end
    end
  end

  // RAM data is only valid in the cycle after the read; the holding register keeps it afterwards.
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dma_rdata = dma_rvalid ? mem_rdata : dma_rdata_q;
  assign owner     = state;

`ifdef ARB_STATS_EN
  dmem_arb_sat_counter #(
    .WIDTH (16)
  ) u_cpu_stats (
    .clk   (clk),
    .reset (reset),
    .clr   (stats_clr),
    .load1 (1'b0),
    .inc   (cpu_gnt),
    .cnt   (cpu_gnt_cnt)
  );

  dmem_arb_sat_counter #(
    .WIDTH (16)
  ) u_dma_stats (
    .clk   (clk),
    .reset (reset),
    .clr   (stats_clr),
    .load1 (1'b0),
    .inc   (dma_gnt),
    .cnt   (dma_gnt_cnt)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural one-cycle-latency RAM.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [9:0]  cpu_addr, dma_addr, mem_addr;
  logic [31:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_en, mem_we;
  logic [31:0] cpu_rdata, dma_rdata;
  logic [1:0]  owner;
`ifdef ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] cpu_gnt_cnt, dma_gnt_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_wdata  (dma_wdata),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .dma_rdata  (dma_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
`ifdef ARB_STATS_EN
    .stats_clr  (stats_clr),
    .cpu_gnt_cnt(cpu_gnt_cnt),
    .dma_gnt_cnt(dma_gnt_cnt),
`endif
    .owner      (owner)
  );

  logic [31:0] ram [0:1023];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    n_tests++;
    if ({cpu_gnt, dma_gnt, mem_en, mem_we} !== 4'b0) begin
      n_fail++; $display("FAIL reset_gnt got=%b exp=0000", {cpu_gnt, dma_gnt, mem_en, mem_we});
    end
    n_tests++;
    if ({cpu_rvalid, dma_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_rvalid got=%b exp=00", {cpu_rvalid, dma_rvalid});
    end
    n_tests++;
    if (mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_mem_fields got=%h/%h exp=0/0", mem_addr, mem_wdata);
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'h010; dma_wdata = 32'hDEADBEEF;
    #1;
    n_tests++;
    if (dma_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h010 || mem_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL preload_write gnt=%b we=%b addr=%h data=%h exp 1 1 010 deadbeef",
                         dma_gnt, mem_we, mem_addr, mem_wdata);
    end
    tick();
    n_tests++;
    if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL preload_no_rvalid got=%b exp=0", dma_rvalid); end
    dma_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
    #1;
    n_tests++;
    if (cpu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h010 || dma_gnt !== 1'b0) begin
      n_fail++; $display("FAIL read_cmd gnt=%b en=%b we=%b addr=%h exp 1 1 0 010",
                         cpu_gnt, mem_en, mem_we, mem_addr);
    end
    tick();
    cpu_req = 1'b0;
    n_tests++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || dma_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL read_data rvalid=%b rdata=%h exp 1 deadbeef", cpu_rvalid, cpu_rdata);
    end
    n_tests++;
    if (owner !== 2'd1) begin n_fail++; $display("FAIL owner_cpu got=%0d exp=1", owner); end
    tick();
    n_tests++;
    if (owner !== 2'd0 || cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL back_to_idle owner=%0d rvalid=%b rdata=%h exp 0 0 deadbeef",
                         owner, cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_burst_rr();
    logic exp_c, prev_c;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'h010;
    prev_c = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      exp_c = (((i / 4) % 2) == 0);
      n_tests++;
      if (cpu_gnt !== exp_c || dma_gnt !== !exp_c || mem_en !== 1'b1) begin
        n_fail++; $display("FAIL burst_gnt cycle=%0d cpu=%b dma=%b exp cpu=%b dma=%b",
                           i, cpu_gnt, dma_gnt, exp_c, !exp_c);
      end
      if (i > 0) begin
        n_tests++;
        if (cpu_rvalid !== prev_c || dma_rvalid !== !prev_c) begin
          n_fail++; $display("FAIL burst_rvalid cycle=%0d cpu=%b dma=%b exp cpu=%b dma=%b",
                             i, cpu_rvalid, dma_rvalid, prev_c, !prev_c);
        end
      end
      prev_c = exp_c;
      tick();
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();
  endtask

  task automatic test_write_then_read();
    tick();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'h3FF; dma_wdata = 32'h12345678;
    #1;
    n_tests++;
    if (dma_gnt !== 1'b1 || mem_addr !== 10'h3FF || mem_we !== 1'b1) begin
      n_fail++; $display("FAIL dma_write gnt=%b addr=%h we=%b exp 1 3ff 1", dma_gnt, mem_addr, mem_we);
    end
    tick();
    dma_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF;
    n_tests++;
    if (dma_rvalid !== 1'b0) begin n_fail++; $display("FAIL dma_write_rvalid got=%b exp=0", dma_rvalid); end
    #1;
    n_tests++;
    if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL cpu_read_gnt got=%b exp=1", cpu_gnt); end
    tick();
    cpu_req = 1'b0;
    n_tests++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678 || dma_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL cpu_read_3ff rvalid=%b rdata=%h dma_rvalid=%b exp 1 12345678 0",
                         cpu_rvalid, cpu_rdata, dma_rvalid);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
    #1;
    n_tests++;
    if (cpu_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt got=%b exp=1", cpu_gnt); end
    tick();
    cpu_req = 1'b0;
    reset = 1'b0;
    #1;
    n_tests++;
    if (cpu_rvalid !== 1'b0 || owner !== 2'd0) begin
      n_fail++; $display("FAIL midrst_async rvalid=%b owner=%0d exp 0 0", cpu_rvalid, owner);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (cpu_rvalid !== 1'b0 || owner !== 2'd0) begin
        n_fail++; $display("FAIL midrst_after cycle=%0d rvalid=%b owner=%0d exp 0 0", i, cpu_rvalid, owner);
      end
    end
  endtask

  task automatic test_cpu_hold();
    bit found;
    int waited;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_tests++;
      if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
        n_fail++; $display("FAIL hold_gnt cycle=%0d cpu=%b dma=%b exp 1 0", i, cpu_gnt, dma_gnt);
      end
      tick();
    end
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 10'h006;
    found = 1'b0;
    waited = 0;
    for (int k = 0; k < 6 && !found; k++) begin
      #1;
      if (dma_gnt === 1'b1) begin
        found = 1'b1;
        waited = k;
      end else begin
        tick();
      end
    end
    n_tests++;
    if (!found || waited > 4) begin
      n_fail++; $display("FAIL hold_dma_wait found=%0d waited=%0d exp found=1 waited<=4", found, waited);
    end
    tick();
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h001; cpu_wdata = 32'h1;
    repeat (5) tick();
    cpu_req = 1'b0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'h002; dma_wdata = 32'h2;
    repeat (3) tick();
    dma_req = 1'b0;
    n_tests++;
    if (cpu_gnt_cnt !== 16'd5 || dma_gnt_cnt !== 16'd3) begin
      n_fail++; $display("FAIL stats_count cpu=%0d dma=%0d exp 5 3", cpu_gnt_cnt, dma_gnt_cnt);
    end
    stats_clr = 1'b1;
    cpu_req = 1'b1;
    tick();
    stats_clr = 1'b0;
    cpu_req = 1'b0;
    n_tests++;
    if (cpu_gnt_cnt !== 16'd0 || dma_gnt_cnt !== 16'd0) begin
      n_fail++; $display("FAIL stats_clr cpu=%0d dma=%0d exp 0 0", cpu_gnt_cnt, dma_gnt_cnt);
    end
    tick();
  endtask
`endif

  initial begin
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
`ifdef ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_single_read();
    test_burst_rr();
    test_write_then_read();
    test_reset_mid_read();
    test_cpu_hold();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data RAM between two requesters: the processor load/store port (CPU) and a program/data loader port (DMA) that fills or dumps memory while the core runs. The arbiter holds a burst-limited ownership FSM, issues one RAM command per cycle and returns read data one cycle later with a valid strobe tagged to the requester. It sits between the core's memory stage, the loader, and the RAM instance.

Parameters:
ADDR_WIDTH, 10, word address width to RAM.
DATA_WIDTH, 32, data width.
MAX_BURST, 4, maximum consecutive grants to one owner while the other requester is waiting (legal range 1..15).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
cpu_req  in  1  CPU access request, held until granted.
cpu_we  in  1  1 = write, 0 = read.
cpu_addr  in  ADDR_WIDTH  CPU word address.
cpu_wdata  in  DATA_WIDTH  CPU write data.
cpu_gnt  out  1  combinational grant; command issued this cycle.
cpu_rvalid  out  1  CPU read data valid (registered).
cpu_rdata  out  DATA_WIDTH  CPU read data.
dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  loader request, same semantics.
dma_gnt  out  1  loader grant.
dma_rvalid  out  1  loader read data valid.
dma_rdata  out  DATA_WIDTH  loader read data.
mem_en  out  1  RAM command strobe.
mem_we  out  1  RAM write enable.
mem_addr  out  ADDR_WIDTH  RAM address.
mem_wdata  out  DATA_WIDTH  RAM write data.
mem_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after a read command.
owner  out  2  current FSM state encoding (debug).

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, burst_cnt=0, last_owner=DMA (so CPU wins the first tie), cpu_rvalid=dma_rvalid=0, rd_tag cleared; gnt/mem_* are 0 because the state is IDLE and no request is seen.
- States: IDLE, OWN_CPU, OWN_DMA. At most one grant per cycle; mem_en = cpu_gnt | dma_gnt. The mem_* fields mux from the granted requester; when there is no grant they are all 0.
- IDLE: one requester active -> grant it, next state OWN_x, burst_cnt=1. Both active -> grant the one not equal to last_owner (round-robin). None -> stay IDLE.
- OWN_x, x requesting, other idle: grant x, no limit (burst_cnt saturates at MAX_BURST).
- OWN_x, x requesting, other requesting: grant x while burst_cnt<MAX_BURST. When burst_cnt==MAX_BURST, grant the other this cycle, switch state, burst_cnt=1.
- OWN_x, x not requesting: other requesting -> grant other, switch, burst_cnt=1; none -> IDLE, last_owner=x.
- Read latency: a granted read sets rd_tag (CPU/DMA) for one cycle. Next cycle the tagged rvalid=1 and rdata=mem_rdata. The untagged rdata holds its last value. Writes never raise rvalid.
- Back-to-back reads every cycle are supported; rvalid may be high in consecutive cycles, interleaved between requesters.
- Requester must keep req/we/addr/wdata stable until gnt; sampling happens only in the gnt cycle.
- Reset mid-read: the pending rvalid is dropped (never asserted after reset release).
- Simultaneous first requests after reset: CPU granted first.

Optional Feature:
ARB_STATS_EN: when defined, adds outputs cpu_gnt_cnt and dma_gnt_cnt (16 bits each), saturating grant counters cleared by reset and by input stats_clr (1 bit, synchronous). If a grant and stats_clr occur in the same cycle, the counter becomes 0. When undefined, these ports and stats_clr do not exist and no counter logic is built.

Decomposition:
- Package dmem_arb_pkg: state enum (IDLE=2'd0, OWN_CPU=2'd1, OWN_DMA=2'd2), requester id constants (REQ_CPU=1'b0, REQ_DMA=1'b1), burst counter width constant (4).
- One sub-module: dmem_arb_sat_counter (parameterised width, inc/clr, saturating). Used for burst_cnt and for the stats counters.

Test Plan:
- Reset, then cpu_req=1 read addr 0x010 with mem holding 0xDEADBEEF -> cpu_gnt=1 same cycle, mem_en=1, mem_we=0, mem_addr=0x010; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
- Both request continuously from IDLE, MAX_BURST=4 -> grant pattern C,C,C,C,D,D,D,D,C... with exactly one gnt per cycle.
- DMA writes 0x12345678 to 0x3FF, then CPU reads 0x3FF -> dma_rvalid never set; cpu_rdata=0x12345678 one cycle after cpu_gnt.
- Assert reset low in the cycle after a granted CPU read -> cpu_rvalid stays 0, state IDLE, owner=0 immediately (asynchronous).
- CPU holds req alone for 10 cycles -> 10 consecutive grants, no forced switch; DMA then requests -> granted at the latest 4 cycles later.
- ARB_STATS_EN: 5 CPU and 3 DMA grants -> cpu_gnt_cnt=5, dma_gnt_cnt=3; pulse stats_clr -> both 0 next cycle.
